// File: rtl/memory_arbiter.sv
// Purpose : shares one backing-memory port between L1I (read) and L1D (read/write); optional MEMORY_ARBITER_ROUND_ROBIN_EN.
// Latency : grant -> mem_req next cycle; done one cycle after mem_ready (2 cycles minimum); abort after MAX_WAIT busy cycles.
// Backpr. : one transaction at a time; losers see stall while req is high; one dead IDLE cycle after each done pulse.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  l1i_req,
  input  logic [ADDR_WIDTH-1:0] l1i_address,
  input  logic                  l1d_req,
  input  logic                  l1d_write,
  input  logic [ADDR_WIDTH-1:0] l1d_address,
  input  logic [DATA_WIDTH-1:0] l1d_write_data,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  l1i_done,
  output logic                  l1d_done,
  output logic                  stall_l1i,
  output logic                  stall_l1d,
  output logic                  timeout_error
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t        state, state_next;
  logic          last_grant, last_grant_next;
  logic [CW-1:0] wait_cnt;
  logic          grant_i, grant_d, pick_d, finish, expired;

  // Stall is a pure function of the live request and this cycle's done pulse.
  assign stall_l1i = l1i_req && !l1i_done;
  assign stall_l1d = l1d_req && !l1d_done;

  // Next-state, grant selection and completion/timeout detection.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    grant_i         = 1'b0;
    grant_d         = 1'b0;
    finish          = 1'b0;
    expired         = 1'b0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    // On contention, serve whoever was not served last.
    pick_d = l1d_req && (!l1i_req || last_grant == GRANT_I);
`else
    // Fixed L1D priority; last_grant is tracked but does not steer.
    pick_d = l1d_req;
`endif
    case (state)
      IDLE: begin
        // A done pulse marks the dead slot that lets the finisher drop req.
        if (!(l1i_done || l1d_done) && (l1i_req || l1d_req)) begin
          if (pick_d) begin
            grant_d         = 1'b1;
            state_next      = BUSY_D;
            last_grant_next = GRANT_D;
          end else begin
            grant_i         = 1'b1;
            state_next      = BUSY_I;
            last_grant_next = GRANT_I;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          finish = 1'b1;
        end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
          // This is the MAX_WAIT-th busy cycle without a response.
          finish  = 1'b1;
          expired = 1'b1;
        end
        if (finish) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and grant-history registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  // Memory-side request latch, wait counter, read-data return and done pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_req        <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      output_data    <= '0;
      l1i_done       <= 1'b0;
      l1d_done       <= 1'b0;
      timeout_error  <= 1'b0;
      wait_cnt       <= '0;
    end else begin
      l1i_done <= 1'b0;
      l1d_done <= 1'b0;
      if (grant_i || grant_d) begin
        // Instruction fetches never write, so their store data is zeroed.
        mem_req        <= 1'b1;
        mem_write      <= grant_d && l1d_write;
        mem_address    <= grant_d ? l1d_address : l1i_address;
        mem_write_data <= grant_d ? l1d_write_data : '0;
        wait_cnt       <= '0;
      end
      if (state != IDLE && !finish) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (finish) begin
        mem_req  <= 1'b0;
        wait_cnt <= '0;
        l1i_done <= (state == BUSY_I);
        l1d_done <= (state == BUSY_D);
        if (expired) begin
          output_data   <= '0;
          timeout_error <= 1'b1;
        end else if (!mem_write) begin
          output_data <= mem_read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter: transaction-level reference model plus scoreboard.
// Stimulus predicts each transaction's grant/done cycles and results; a monitor checks them.
// Build with MEMORY_ARBITER_ROUND_ROBIN_EN defined to check the alternating-priority variant.
module tb_memory_arbiter;

  localparam int MW = 15;

  logic        clock, reset;
  logic        l1i_req, l1d_req, l1d_write;
  logic [31:0] l1i_address, l1d_address, l1d_write_data;
  logic        mem_req, mem_write, mem_ready;
  logic [31:0] mem_address, mem_write_data, mem_read_data, output_data;
  logic        l1i_done, l1d_done, stall_l1i, stall_l1d, timeout_error;

  memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(MW)) dut (
    .clock(clock), .reset(reset),
    .l1i_req(l1i_req), .l1i_address(l1i_address),
    .l1d_req(l1d_req), .l1d_write(l1d_write), .l1d_address(l1d_address),
    .l1d_write_data(l1d_write_data),
    .mem_req(mem_req), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_ready(mem_ready), .mem_read_data(mem_read_data),
    .output_data(output_data), .l1i_done(l1i_done), .l1d_done(l1d_done),
    .stall_l1i(stall_l1i), .stall_l1d(stall_l1d), .timeout_error(timeout_error)
  );

  typedef struct {
    bit          who;     // 0 = L1I, 1 = L1D
    logic [31:0] addr;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          grant;   // cycle in which the arbiter accepts the request
    int          done;    // cycle in which the done pulse is visible
    bit          to;      // aborted by timeout
  } txn_t;

  txn_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- stimulus + reference model ----------------
  int   free_at;            // first cycle a new grant may happen
  bit   lg;                 // last granted requester
  int   st_i, st_d;         // 0 idle, 1 requesting, 2 granted
  int   done_i, done_d;
  bit   cur_v;
  int   cur_grant, cur_done, cur_ready;
  logic [31:0] cur_rdata;
  int   p_raise, p_long, p_reset, p_drop, ncyc;
  bit   tie;
  txn_t t;

  initial begin
    int lat, k;
    bit win_d, to;
    reset = 1'b1; l1i_req = 1'b0; l1d_req = 1'b0; l1d_write = 1'b0;
    l1i_address = '0; l1d_address = '0; l1d_write_data = '0;
    mem_ready = 1'b0; mem_read_data = '0;
    lg = 1'b0; st_i = 0; st_d = 0; cur_v = 1'b0; done_i = 0; done_d = 0;
    cur_grant = 0; cur_done = 0; cur_ready = -1; cur_rdata = '0;
    repeat (3) @(negedge clock);
    free_at = cyc + 1;

    for (int ph = 0; ph < 5; ph++) begin
      case (ph)
        0:       begin p_raise = 8;  p_long = 0; p_reset = 0; p_drop = 0; tie = 1; ncyc = 1200; end
        1:       begin p_raise = 16; p_long = 0; p_reset = 0; p_drop = 0; tie = 1; ncyc = 600;  end
        2:       begin p_raise = 6;  p_long = 4; p_reset = 0; p_drop = 4; tie = 0; ncyc = 1200; end
        3:       begin p_raise = 10; p_long = 6; p_reset = 8; p_drop = 3; tie = 0; ncyc = 1200; end
        default: begin p_raise = 0;  p_long = 0; p_reset = 0; p_drop = 0; tie = 0; ncyc = 60;   end
      endcase
      for (int n = 0; n < ncyc; n++) begin
        @(negedge clock);
        // Payload inputs are scrambled every cycle: only the grant-cycle values matter.
        l1i_address    = $urandom;
        l1d_address    = $urandom;
        l1d_write_data = $urandom;
        l1d_write      = 1'($urandom_range(1));
        if (int'($urandom_range(999)) < p_reset) begin
          reset = 1'b1; l1i_req = 1'b0; l1d_req = 1'b0;
          st_i = 0; st_d = 0; cur_v = 1'b0; lg = 1'b0;
          sb.delete();
          free_at = cyc + 1;
          mem_ready = 1'($urandom_range(1)); mem_read_data = $urandom;
          continue;
        end
        reset = 1'b0;
        // requester behaviour: hold until done, occasionally drop after grant
        if (st_i == 2 && cyc == done_i) begin l1i_req = 1'b0; st_i = 0; end
        else if (st_i == 2 && int'($urandom_range(15)) < p_drop) l1i_req = 1'b0;
        if (st_i == 0 && int'($urandom_range(15)) < p_raise) begin st_i = 1; l1i_req = 1'b1; end
        if (st_d == 2 && cyc == done_d) begin l1d_req = 1'b0; st_d = 0; end
        else if (st_d == 2 && int'($urandom_range(15)) < p_drop) l1d_req = 1'b0;
        if (st_d == 0 && int'($urandom_range(15)) < p_raise) begin st_d = 1; l1d_req = 1'b1; end
        // arbitration model
        if (cyc >= free_at && (l1i_req || l1d_req)) begin
          if (l1i_req && l1d_req) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            win_d = (lg != 1'b1);
`else
            win_d = 1'b1;
`endif
          end else begin
            win_d = l1d_req;
          end
          if (tie) lat = 1;
          else if (int'($urandom_range(15)) < p_long) lat = $urandom_range(1, MW + 4);
          else lat = $urandom_range(1, 3);
          to = (lat > MW);
          k  = to ? MW : lat;
          t.who   = win_d;
          t.addr  = win_d ? l1d_address : l1i_address;
          t.wr    = win_d && l1d_write;
          t.wdata = win_d ? l1d_write_data : 32'h0;
          t.rdata = $urandom;
          t.grant = cyc;
          t.done  = cyc + k + 1;
          t.to    = to;
          sb.push_back(t);
          lg = win_d;
          free_at = cyc + k + 2;
          cur_v = 1'b1; cur_grant = cyc; cur_done = t.done;
          cur_ready = to ? -1 : cyc + lat; cur_rdata = t.rdata;
          if (win_d) begin st_d = 2; done_d = t.done; end
          else       begin st_i = 2; done_i = t.done; end
        end
        // backing memory: respond exactly when planned, junk in IDLE
        if (cur_v && cyc == cur_ready) begin
          mem_ready = 1'b1; mem_read_data = cur_rdata;
        end else if (cur_v && cyc > cur_grant && cyc < cur_done) begin
          mem_ready = 1'b0; mem_read_data = $urandom;
        end else begin
          mem_ready = 1'($urandom_range(1)); mem_read_data = $urandom;
        end
      end
    end
    @(negedge clock);
    check("drain_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] mon_out = '0;
  bit          mon_err = 1'b0;
  bit          exp_id, exp_dd, exp_req;

  always @(posedge clock) begin
    #1;
    if (reset) begin
      mon_out = '0;
      mon_err = 1'b0;
      check("rst_mem_address", mem_address, 0);
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_write_data", mem_write_data, 0);
    end
    exp_id = 1'b0; exp_dd = 1'b0; exp_req = 1'b0;
    if (sb.size() > 0) begin
      exp_req = (cyc > sb[0].grant) && (cyc < sb[0].done);
      exp_id  = (cyc == sb[0].done) && !sb[0].who;
      exp_dd  = (cyc == sb[0].done) &&  sb[0].who;
    end
    check("l1i_done", l1i_done, exp_id);
    check("l1d_done", l1d_done, exp_dd);
    check("mem_req", mem_req, exp_req);
    check("stall_l1i", stall_l1i, l1i_req && !exp_id);
    check("stall_l1d", stall_l1d, l1d_req && !exp_dd);
    if (exp_req) begin
      check("mem_address", mem_address, sb[0].addr);
      check("mem_write", mem_write, sb[0].wr);
      check("mem_write_data", mem_write_data, sb[0].wdata);
    end
    if (sb.size() > 0 && cyc == sb[0].done) begin
      if (sb[0].to) mon_out = '0;
      else if (!sb[0].wr) mon_out = sb[0].rdata;
      mon_err = mon_err || sb[0].to;
      void'(sb.pop_front());
    end
    check("output_data", output_data, mon_out);
    check("timeout_error", timeout_error, mon_err);
  end

endmodule
